// File: rtl/adder16_mp_sched.sv
// Two-requester scheduler that serialises up to 64-bit additions through one
// 16-bit carry-lookahead adder, one word per cycle, and holds each result until consumed.

module adder16_carry_ahead (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);
    logic [15:0] g;
    logic [15:0] p;

    assign g = a & b;
    assign p = a ^ b;

    // Four 4-bit groups: group generate/propagate, then carries into each group,
    // then the bit carries inside each group.
    always_comb begin
        logic [3:0]  gg;
        logic [3:0]  gp;
        logic [4:0]  gc;
        logic [16:0] c;
        gg = '0;
        gp = '0;
        gc = '0;
        c  = '0;
        for (int i = 0; i < 4; i++) begin
            gg[i] = g[4*i+3]
                  | (p[4*i+3] & g[4*i+2])
                  | (p[4*i+3] & p[4*i+2] & g[4*i+1])
                  | (p[4*i+3] & p[4*i+2] & p[4*i+1] & g[4*i]);
            gp[i] = &p[4*i +: 4];
        end
        gc[0] = cin;
        for (int i = 0; i < 4; i++) begin
            gc[i+1] = gg[i] | (gp[i] & gc[i]);
        end
        for (int i = 0; i < 4; i++) begin
            c[4*i] = gc[i];
            for (int j = 1; j < 4; j++) begin
                c[4*i+j] = g[4*i+j-1] | (p[4*i+j-1] & c[4*i+j-1]);
            end
        end
        c[16] = gc[4];
        sum   = p ^ c[15:0];
        cout  = c[16];
    end
endmodule

module adder16_mp_sched #(
    parameter bit RR_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [63:0] req0_a,
    input  logic [63:0] req0_b,
    input  logic [63:0] req1_a,
    input  logic [63:0] req1_b,
    input  logic [1:0]  req0_len,
    input  logic [1:0]  req1_len,
    input  logic        req0_cin,
    input  logic        req1_cin,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [63:0] rsp_sum,
    output logic        rsp_cout
);
    // Handshake: a request transfers on a cycle where req_valid[i] && req_ready[i];
    // a response transfers on a cycle where rsp_valid && rsp_ready, and its payload
    // is held unchanged while rsp_valid is high and rsp_ready is low.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [63:0] a_q;
    logic [63:0] b_q;
    logic [63:0] sum_q;
    logic [1:0]  len_q;
    logic [1:0]  beat;
    logic        cin_q;
    logic        id_q;
    logic        carry_q;
    logic        ptr;

    logic        gnt_id;
    logic        accept;
    logic [63:0] sel_a;
    logic [63:0] sel_b;
    logic [1:0]  sel_len;
    logic        sel_cin;

    logic [5:0]  word_lsb;
    logic [15:0] add_a;
    logic [15:0] add_b;
    logic [15:0] add_sum;
    logic        add_cin;
    logic        add_cout;

    // Grant selection: ptr names the favoured requester when both ask.
    always_comb begin
        gnt_id = 1'b0;
        if (RR_EN) begin
            gnt_id = (&req_valid) ? ptr : req_valid[1];
        end else begin
            gnt_id = ~req_valid[0] & req_valid[1];
        end
    end

    always_comb begin
        sel_a   = gnt_id ? req1_a   : req0_a;
        sel_b   = gnt_id ? req1_b   : req0_b;
        sel_len = gnt_id ? req1_len : req0_len;
        sel_cin = gnt_id ? req1_cin : req0_cin;
    end

    // req_ready is qualified by rst_n so it drops the instant reset asserts.
    always_comb begin
        state_nxt = state;
        req_ready = 2'b00;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (rst_n && (|req_valid)) begin
                    accept    = 1'b1;
                    req_ready = gnt_id ? 2'b10 : 2'b01;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (beat == len_q) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    assign word_lsb = {beat, 4'b0000};
    assign add_a    = a_q[word_lsb +: 16];
    assign add_b    = b_q[word_lsb +: 16];
    assign add_cin  = (beat == 2'd0) ? cin_q : carry_q;

    adder16_carry_ahead u_add (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Clearing sum_q on acceptance is what keeps words above len at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            len_q   <= '0;
            beat    <= '0;
            cin_q   <= 1'b0;
            id_q    <= 1'b0;
            carry_q <= 1'b0;
            ptr     <= 1'b0;
        end else if (accept) begin
            a_q     <= sel_a;
            b_q     <= sel_b;
            sum_q   <= '0;
            len_q   <= sel_len;
            beat    <= '0;
            cin_q   <= sel_cin;
            id_q    <= gnt_id;
            carry_q <= 1'b0;
            if (RR_EN) begin
                ptr <= ~gnt_id;
            end
        end else if (state == RUN) begin
            sum_q[word_lsb +: 16] <= add_sum;
            carry_q               <= add_cout;
            beat                  <= beat + 2'd1;
        end
    end

    assign rsp_valid = (state == DONE);
    assign rsp_sum   = sum_q;
    assign rsp_cout  = carry_q;
    assign rsp_id    = id_q;

endmodule

// File: tb/tb_adder16_mp_sched.sv
// Self-checking bench for adder16_mp_sched: directed scenarios, arbitration for both
// policies, response stalls, reset mid-operation and a long randomized run.

module tb_adder16_mp_sched;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req0_a, req0_b, req1_a, req1_b;
    logic [1:0]  req0_len, req1_len;
    logic        req0_cin, req1_cin;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_cout;
    logic [63:0] rsp_sum;

    logic [1:0]  fp_req_valid;
    logic [1:0]  fp_req_ready;
    logic        fp_rsp_valid, fp_rsp_ready, fp_rsp_id, fp_rsp_cout;
    logic [63:0] fp_rsp_sum;

    int          checks = 0;
    int          errors = 0;
    logic [65:0] exp_q[$];

    adder16_mp_sched #(.RR_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .req0_len(req0_len), .req1_len(req1_len), .req0_cin(req0_cin), .req1_cin(req1_cin),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_sum(rsp_sum), .rsp_cout(rsp_cout)
    );

    adder16_mp_sched #(.RR_EN(1'b0)) dut_fp (
        .clk(clk), .rst_n(rst_n), .req_valid(fp_req_valid), .req_ready(fp_req_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .req0_len(req0_len), .req1_len(req1_len), .req0_cin(req0_cin), .req1_cin(req1_cin),
        .rsp_valid(fp_rsp_valid), .rsp_ready(fp_rsp_ready), .rsp_id(fp_rsp_id),
        .rsp_sum(fp_rsp_sum), .rsp_cout(fp_rsp_cout)
    );

    // Reference: plain wide addition of the operands masked to (len+1) words.
    function automatic logic [64:0] ref_model(input logic [63:0] a, input logic [63:0] b,
                                              input logic [1:0] len, input logic cin);
        int          w;
        logic [64:0] mask;
        logic [64:0] t;
        w    = 16 * (int'(len) + 1);
        mask = (65'd1 << w) - 65'd1;
        t    = ({1'b0, a} & mask) + ({1'b0, b} & mask) + {64'd0, cin};
        return {t[w], t[63:0] & mask[63:0]};
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        rst_n        = 1'b0;
        req_valid    = 2'b00;
        fp_req_valid = 2'b00;
        rsp_ready    = 1'b0;
        fp_rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drive_req(input logic id, input logic [63:0] a, input logic [63:0] b,
                             input logic [1:0] len, input logic cin);
        if (id) begin
            req1_a = a; req1_b = b; req1_len = len; req1_cin = cin;
            req0_a = {$urandom, $urandom}; req0_b = {$urandom, $urandom};
            req0_len = 2'($urandom_range(0, 3)); req0_cin = 1'($urandom_range(0, 1));
            req_valid = 2'b10;
        end else begin
            req0_a = a; req0_b = b; req0_len = len; req0_cin = cin;
            req1_a = {$urandom, $urandom}; req1_b = {$urandom, $urandom};
            req1_len = 2'($urandom_range(0, 3)); req1_cin = 1'($urandom_range(0, 1));
            req_valid = 2'b01;
        end
    endtask

    task automatic do_op(input logic id, input logic [63:0] a, input logic [63:0] b,
                         input logic [1:0] len, input logic cin, input int stall);
        int          cnt;
        logic        got;
        logic [63:0] held;
        logic [65:0] exp;
        drive_req(id, a, b, len, cin);
        #1;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (req_ready[id]) begin
                got = 1'b1;
                break;
            end
            step();
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL op_grant id=%0d req_ready=%b required grant", id, req_ready);
            req_valid = 2'b00;
            return;
        end
        exp_q.push_back({id, ref_model(a, b, len, cin)});
        step();
        req_valid = 2'b00;
        cnt = 1;
        while (!rsp_valid && cnt < 40) begin
            step();
            cnt++;
        end
        exp = exp_q.pop_front();
        checks++;
        if (cnt != int'(len) + 2) begin
            errors++;
            $display("FAIL op_latency got=%0d required=%0d", cnt, int'(len) + 2);
        end
        if (!rsp_valid) return;
        held = rsp_sum;
        for (int s = 0; s < stall; s++) begin
            step();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_sum !== held || req_ready !== 2'b00) begin
                errors++;
                $display("FAIL op_hold valid=%b sum=%h required sum=%h ready=%b", rsp_valid,
                         rsp_sum, held, req_ready);
            end
        end
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (rsp_sum !== exp[63:0]) begin
            errors++;
            $display("FAIL op_sum got=%h required=%h", rsp_sum, exp[63:0]);
        end
        checks++;
        if (rsp_cout !== exp[64]) begin
            errors++;
            $display("FAIL op_cout got=%b required=%b", rsp_cout, exp[64]);
        end
        checks++;
        if (rsp_id !== exp[65]) begin
            errors++;
            $display("FAIL op_id got=%b required=%b", rsp_id, exp[65]);
        end
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        req0_len = '0; req1_len = '0; req0_cin = 1'b0; req1_cin = 1'b0;
        req_valid = 2'b11; fp_req_valid = 2'b11;
        rsp_ready = 1'b0; fp_rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (req_ready !== 2'b00 || fp_req_ready !== 2'b00) begin
            errors++;
            $display("FAIL reset_ready got=%b/%b required=00", req_ready, fp_req_ready);
        end
        checks++;
        if (rsp_valid !== 1'b0 || rsp_sum !== 64'd0 || rsp_cout !== 1'b0 || rsp_id !== 1'b0) begin
            errors++;
            $display("FAIL reset_rsp valid=%b sum=%h cout=%b id=%b required all 0",
                     rsp_valid, rsp_sum, rsp_cout, rsp_id);
        end
        apply_reset();
    endtask

    task automatic test_scenarios;
        do_op(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 2'd3, 1'b0, 0);
        do_op(1'b1, 64'hFFFF_FFFF_FFFF_8000, 64'hFFFF_FFFF_FFFF_8000, 2'd0, 1'b1, 0);
        do_op(1'b0, 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_0000_0001, 2'd1, 1'b0, 2);
        do_op(1'b1, 64'h1234_FFFF_FFFF_0001, 64'hFFFF_0000_0001_FFFF, 2'd2, 1'b1, 1);
    endtask

    task automatic test_stall;
        logic [64:0] exp;
        logic [63:0] held;
        logic        got;
        int          cnt;
        drive_req(1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 2'd1, 1'b1);
        exp = ref_model(req0_a, req0_b, 2'd1, 1'b1);
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL stall_grant got=%b required=01", req_ready);
        end
        step();
        req_valid = 2'b10;
        cnt = 0;
        while (!rsp_valid && cnt < 20) begin
            step();
            cnt++;
        end
        held = rsp_sum;
        for (int s = 0; s < 10; s++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_sum !== held || req_ready !== 2'b00) begin
                errors++;
                $display("FAIL stall_hold cycle=%0d valid=%b sum=%h required=%h ready=%b",
                         s, rsp_valid, rsp_sum, held, req_ready);
            end
            step();
        end
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (rsp_sum !== exp[63:0] || rsp_cout !== exp[64] || req_ready !== 2'b00) begin
            errors++;
            $display("FAIL stall_result sum=%h cout=%b ready=%b required sum=%h cout=%b ready=00",
                     rsp_sum, rsp_cout, req_ready, exp[63:0], exp[64]);
        end
        step();
        rsp_ready = 1'b0;
        #1;
        checks++;
        if (req_ready !== 2'b10) begin
            errors++;
            $display("FAIL stall_next_grant got=%b required=10", req_ready);
        end
        exp = ref_model(req1_a, req1_b, req1_len, req1_cin);
        step();
        req_valid = 2'b00;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
            step();
        end
        checks++;
        if (!got || rsp_sum !== exp[63:0] || rsp_cout !== exp[64] || rsp_id !== 1'b1) begin
            errors++;
            $display("FAIL stall_follow valid=%b sum=%h cout=%b id=%b required sum=%h cout=%b id=1",
                     rsp_valid, rsp_sum, rsp_cout, rsp_id, exp[63:0], exp[64]);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic test_arbitration;
        logic [1:0]  exp_rdy;
        logic        exp_id;
        logic        got;
        logic [64:0] exp;
        apply_reset();
        req0_a = {$urandom, $urandom}; req0_b = {$urandom, $urandom};
        req1_a = {$urandom, $urandom}; req1_b = {$urandom, $urandom};
        req0_len = 2'd2; req1_len = 2'd1; req0_cin = 1'b1; req1_cin = 1'b0;
        req_valid = 2'b11;
        #1;
        for (int i = 0; i < 4; i++) begin
            exp_id  = 1'(i % 2);
            exp_rdy = exp_id ? 2'b10 : 2'b01;
            checks++;
            if (req_ready !== exp_rdy) begin
                errors++;
                $display("FAIL rr_grant op=%0d got=%b required=%b", i, req_ready, exp_rdy);
            end
            exp = exp_id ? ref_model(req1_a, req1_b, req1_len, req1_cin)
                         : ref_model(req0_a, req0_b, req0_len, req0_cin);
            step();
            got = 1'b0;
            for (int c = 0; c < 20; c++) begin
                if (rsp_valid) begin
                    got = 1'b1;
                    break;
                end
                step();
            end
            checks++;
            if (!got || rsp_id !== exp_id || rsp_sum !== exp[63:0] || rsp_cout !== exp[64]) begin
                errors++;
                $display("FAIL rr_rsp op=%0d valid=%b id=%b sum=%h required id=%b sum=%h",
                         i, rsp_valid, rsp_id, rsp_sum, exp_id, exp[63:0]);
            end
            rsp_ready = 1'b1;
            step();
            rsp_ready = 1'b0;
            #1;
        end
        req_valid = 2'b00;

        fp_req_valid = 2'b11;
        exp = ref_model(req0_a, req0_b, req0_len, req0_cin);
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (fp_req_ready !== 2'b01) begin
                errors++;
                $display("FAIL fp_grant op=%0d got=%b required=01", i, fp_req_ready);
            end
            step();
            got = 1'b0;
            for (int c = 0; c < 20; c++) begin
                if (fp_rsp_valid) begin
                    got = 1'b1;
                    break;
                end
                step();
            end
            checks++;
            if (!got || fp_rsp_id !== 1'b0 || fp_rsp_sum !== exp[63:0] || fp_rsp_cout !== exp[64]) begin
                errors++;
                $display("FAIL fp_rsp op=%0d valid=%b id=%b sum=%h required id=0 sum=%h",
                         i, fp_rsp_valid, fp_rsp_id, fp_rsp_sum, exp[63:0]);
            end
            fp_rsp_ready = 1'b1;
            step();
            fp_rsp_ready = 1'b0;
            #1;
        end
        fp_req_valid = 2'b00;
    endtask

    task automatic test_reset_mid;
        logic seen;
        drive_req(1'b1, 64'h1234_5678_9ABC_DEF0, 64'h0F0F_0F0F_0F0F_0F0F, 2'd3, 1'b0);
        step();
        req_valid = 2'b00;
        step();
        checks++;
        if (rsp_sum === 64'd0) begin
            errors++;
            $display("FAIL mid_progress sum=%h required nonzero word 0", rsp_sum);
        end
        #2;
        req_valid = 2'b01;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_sum !== 64'd0 || rsp_cout !== 1'b0 ||
            rsp_id !== 1'b0 || req_ready !== 2'b00) begin
            errors++;
            $display("FAIL mid_reset valid=%b sum=%h cout=%b id=%b ready=%b required all 0",
                     rsp_valid, rsp_sum, rsp_cout, rsp_id, req_ready);
        end
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (rsp_valid) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL mid_no_rsp got rsp_valid=1 required 0 after aborted op");
        end
        do_op(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 2'd3, 1'b1, 0);
    endtask

    task automatic test_random;
        int stall;
        for (int n = 0; n < 10000; n++) begin
            stall = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
            do_op(1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom},
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), stall);
        end
    endtask

    initial begin
        test_reset();
        test_scenarios();
        test_stall();
        test_arbitration();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adder16_mp_sched.md
ADDER16_MP_SCHED -- requirements
Module: adder16_mp_sched

Interface
REQ-001 Parameter RR_EN, default 1, arbitration policy: 1 = round-robin, 0 = fixed priority with requester 0 highest.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 req_valid  input  2  per-requester operation valid; bit i belongs to requester i.
REQ-005 req_ready  output  2  per-requester accept; the handshake completes on a cycle where req_valid[i] and req_ready[i] are both 1.
REQ-006 req0_a, req0_b, req1_a, req1_b  input  64  per-requester operands.
REQ-007 req0_len, req1_len  input  2  number of 16-bit words to add, minus 1 (0 = 16-bit add, 3 = 64-bit add).
REQ-008 req0_cin, req1_cin  input  1  carry into word 0.
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_ready  input  1  consumer accepts the result.
REQ-011 rsp_id  output  1  requester that owns the result.
REQ-012 rsp_sum  output  64  result; words above len are 0.
REQ-013 rsp_cout  output  1  carry out of the last processed word.

Function
REQ-014 The block SHALL instantiate exactly one adder16_carry_ahead and perform every addition through it, one 16-bit word per cycle.
REQ-015 The FSM SHALL have the states IDLE, RUN and DONE; reset enters IDLE.
REQ-016 In IDLE, req_ready SHALL be one-hot on the granted requester when any req_valid is 1, and 0 otherwise; req_ready SHALL be 0 in RUN and DONE.
REQ-017 RR_EN=1: when both requesters are valid, the grant SHALL go to the requester not granted last; after reset the priority pointer favours requester 0.
REQ-018 RR_EN=0: requester 0 SHALL win whenever req0 is valid.
REQ-019 On acceptance, the block SHALL latch the operands, len, cin and the id, clear the result register, and move to RUN.
REQ-020 RUN, beat k (k = 0..len): the adder inputs SHALL be a[16k+15:16k] and b[16k+15:16k].
REQ-021 RUN, beat k: the adder carry-in SHALL be the latched cin for k = 0, and the registered cout of beat k-1 for k > 0.
REQ-022 Each beat SHALL write sum word k and register the carry.
REQ-023 After beat len, the FSM SHALL go to DONE.
REQ-024 Latency: acceptance at cycle T gives rsp_valid = 1 at cycle T+len+2; RUN occupies len+1 cycles.
REQ-025 In DONE, rsp_valid SHALL be 1 and rsp_sum, rsp_cout and rsp_id SHALL stay stable until rsp_ready = 1.
REQ-026 On the DONE cycle where rsp_ready = 1, the FSM SHALL return to IDLE; the next grant occurs in the following cycle at the earliest, with no back-to-back bypass.
REQ-027 rsp_cout SHALL be the carry out of word len, not of word 3.
REQ-028 Operand bits above word len SHALL be ignored.
REQ-029 A requester dropping req_valid before it is granted SHALL lose no state and SHALL cause no error.

Reset
REQ-030 rst_n = 0 SHALL immediately force the state to IDLE and set req_ready = 0, rsp_valid = 0, rsp_sum = 0, rsp_cout = 0, rsp_id = 0 and the priority pointer to requester 0.
REQ-031 Reset asserted in RUN or DONE SHALL abort the operation with no response; after release, the block behaves as freshly reset.

Verification
REQ-032 Scenario: req0, len = 3, a = 64'hFFFF_FFFF_FFFF_FFFF, b = 1, cin = 0 -> rsp_sum = 0, rsp_cout = 1, rsp_id = 0, rsp_valid 5 cycles after acceptance.
REQ-033 Scenario: req1, len = 0, a = 16'h8000, b = 16'h8000, cin = 1, upper operand bits all 1 -> rsp_sum = 64'h1, rsp_cout = 1, latency 2.
REQ-034 Scenario: RR_EN = 1, both requesters held valid for 4 operations -> grants in the order 0, 1, 0, 1 with rsp_id matching; with RR_EN = 0 -> all 4 grants go to requester 0.
REQ-035 Scenario: rsp_ready held 0 for 10 cycles in DONE -> rsp_valid and rsp_sum stable and req_ready = 0 throughout; the next grant comes 1 cycle after rsp_ready rises.
REQ-036 Scenario: rst_n pulsed low in RUN beat 1 -> all outputs 0 asynchronously, no rsp_valid afterward; a subsequent request completes correctly.
REQ-037 Scenario: 10k random operations with random len, cin and rsp_ready stalls -> results match a 64-bit reference model masked to (len+1) words, and carries match.
